// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit that owns the HI/LO registers.
// Each operation takes 32 shift-add or restoring-divide steps plus one sign-fix cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;    // multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}
    logic [31:0] r_opnd;   // multiplicand or divisor magnitude
    logic        r_is_div;
    logic        r_signed;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_div0;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_op_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic [63:0] w_acc_step;
    logic        w_neg_res;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_unused;

    assign w_op_signed = ~op[0];
    assign w_abs_a     = (w_op_signed && A[31]) ? -A : A;
    assign w_abs_b     = (w_op_signed && B[31]) ? -B : B;

    assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_div_shift = r_acc[63:31];
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};

    // A negative trial difference means restore: keep the shifted remainder, quotient bit 0.
    always_comb begin
        w_acc_step = r_acc;
        if (!r_is_div)
            w_acc_step = {w_mul_sum, r_acc[31:1]};
        else if (!w_div_diff[33])
            w_acc_step = {w_div_diff[31:0], r_acc[30:0], 1'b1};
        else
            w_acc_step = {w_div_shift[31:0], r_acc[30:0], 1'b0};
    end

    assign w_neg_res  = r_signed & (r_sign_a ^ r_sign_b);
    assign w_prod_fix = w_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = w_neg_res ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem_fix  = (r_signed && r_sign_a) ? -r_acc[63:32] : r_acc[63:32];
    assign w_unused   = ^{w_div_diff[32]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_cnt    <= 5'd0;
                        r_is_div <= op[1];
                        r_signed <= w_op_signed;
                        r_sign_a <= w_op_signed & A[31];
                        r_sign_b <= w_op_signed & B[31];
                        r_div0   <= (B == 32'd0);
                        if (op[1]) begin
                            r_acc  <= {32'd0, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {32'd0, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                    end else begin
                        if (hi_we)
                            r_hi <= wdata;
                        if (lo_we)
                            r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= S_FIN;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end else begin
                        // Zero divisor leaves the dividend as remainder; only LO needs overriding.
                        r_hi <= w_rem_fix;
                        r_lo <= r_div0 ? 32'hFFFF_FFFF : w_quo_fix;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
